out_queue: RTL and testbench
============================

OUT_QUEUE -- requirements
Module: out_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of byte entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 SHALL have port doOut  input  1  output-strobe control bit; requests capture of dbus this cycle.
REQ-005 SHALL have port dbus  input  8  data bus value captured when doOut is high.
REQ-006 SHALL have port ovfClear  input  1  clears the sticky overflow status.
REQ-007 SHALL have port outReady  input  1  downstream consumer accepts the head byte.
REQ-008 SHALL have port outValid  output  1  head byte present; high exactly when count is nonzero.
REQ-009 SHALL have port outData  output  8  oldest stored byte; don't-care when outValid is low.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH.
REQ-011 SHALL have port full  output  1  high exactly when count equals DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag; a byte was dropped since the last clear.
REQ-013 SHALL have port dropCount  output  8  number of dropped bytes, saturating at 255.

Function
REQ-014 SHALL be a circular FIFO: write pointer, read pointer and count registers; both pointers wrap modulo DEPTH.
REQ-015 SHALL define pop as outValid && outReady in the same cycle; on pop, read pointer advances by one at the posedge.
REQ-016 SHALL define push as doOut && (!full || pop); on push, dbus is written at the write pointer and the write pointer advances at the posedge.
REQ-017 SHALL update count as +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-018 SHALL make a pushed byte visible on outData/outValid in the cycle after the push edge; no same-cycle bypass from dbus to outData.
REQ-019 SHALL, when empty, with doOut and outReady both high, push the byte, perform no pop, and end with count = 1.
REQ-020 SHALL, when full, with doOut high and a pop in the same cycle, accept the new byte and keep count = DEPTH.
REQ-021 SHALL, when full, with doOut high and no pop, drop the byte, leave the FIFO unchanged, set overflow, and increment dropCount (hold at 255).
REQ-022 SHALL hold outData stable, never reorder entries and keep FIFO order while outValid is high and outReady is low.
REQ-023 SHALL, on ovfClear, set overflow to 0 and dropCount to 0 at the next edge; if a drop occurs in the same cycle, the result is overflow = 1 and dropCount = 1.
REQ-024 SHALL ignore outReady when outValid is low: no pointer movement, no underflow.
REQ-025 SHALL derive full, outValid and count from registered state only, with no combinational path from inputs.

Reset
REQ-026 SHALL, on reset high at posedge clk, set count = 0, both pointers = 0, overflow = 0 and dropCount = 0; outValid and full are then 0.
REQ-027 SHALL give reset priority over doOut, outReady and ovfClear in the same cycle; any in-flight push or pop is discarded.
REQ-028 SHALL leave storage contents undefined after reset; they are not observable because outValid is 0.

Verification
REQ-029 SHALL cover: after reset, doOut=1 with dbus=0x11,0x22,0x33 on 3 cycles and outReady=0 -> count=3, outData=0x11; then outReady=1 for 3 cycles -> bytes 0x11, 0x22, 0x33 accepted in order, count=0.
REQ-030 SHALL cover: DEPTH=4, push 0xA0..0xA3 -> full=1; push 0xA4 with outReady=0 -> dropped, overflow=1, dropCount=1, outData=0xA0.
REQ-031 SHALL cover: full FIFO, doOut=1 with dbus=0xB5 and outReady=1 in the same cycle -> count stays 4, 0xA0 popped, 0xB5 later emerges last.
REQ-032 SHALL cover: 300 drops while full -> dropCount=255; ovfClear together with one more drop -> overflow=1, dropCount=1.
REQ-033 SHALL cover: push 6 bytes with interleaved pops so the pointers wrap twice -> output order matches input order exactly.
REQ-034 SHALL cover: reset asserted with count=2 and doOut=1 in the same cycle -> next cycle count=0, outValid=0, overflow=0.

Source files
------------

// File: rtl/out_queue.sv
// Output byte queue: circular FIFO between a strobed data bus and a ready/valid consumer,
// with a sticky overflow flag and a saturating count of bytes dropped while full.
module out_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     doOut,
  input  logic [7:0]               dbus,
  input  logic                     ovfClear,
  input  logic                     outReady,
  output logic                     outValid,
  output logic [7:0]               outData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               dropCount
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          full_w, pop, push, drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    full_w     = (count_q == (AW+1)'(DEPTH));
    pop        = (count_q != '0) && outReady;
    // A pop in the same cycle frees the slot the new byte lands in.
    push       = doOut && (!full_w || pop);
    drop       = doOut && full_w && !pop;

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // A clear restarts the tally, so a drop in the same cycle counts as the first.
    if (ovfClear) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc8(drop_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is data-only; a write during reset is harmless since nothing is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dbus;
  end

  assign outValid  = (count_q != '0);
  assign outData   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = full_w;
  assign overflow  = overflow_q;
  assign dropCount = drop_cnt_q;

endmodule

// File: tb/tb_out_queue.sv
// Bench for out_queue (DEPTH=4): directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_out_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0, doOut = 1'b0, ovfClear = 1'b0, outReady = 1'b0;
  logic [7:0] dbus = 8'h00;
  logic       outValid, full, overflow;
  logic [7:0] outData, dropCount;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  bit         movf = 1'b0;
  int         mdc = 0;

  out_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .doOut(doOut), .dbus(dbus), .ovfClear(ovfClear),
    .outReady(outReady), .outValid(outValid), .outData(outData), .count(count),
    .full(full), .overflow(overflow), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, sample after it.
  task automatic step(input bit r, input bit d, input logic [7:0] b, input bit rdy, input bit clr);
    bit do_pop, do_push, do_drop, was_full;
    reset = r; doOut = d; dbus = b; outReady = rdy; ovfClear = clr;
    if (r) begin
      mq.delete(); movf = 1'b0; mdc = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && rdy;
      do_push  = d && (!was_full || do_pop);
      do_drop  = d && was_full && !do_pop;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(b);
      if (clr) begin
        movf = do_drop; mdc = do_drop ? 1 : 0;
      end else if (do_drop) begin
        movf = 1'b1; mdc = (mdc < 255) ? mdc + 1 : 255;
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; doOut = 1'b0; outReady = 1'b0; ovfClear = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 8'h00, 0, 0);
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", outValid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (overflow !== 1'b0 || dropCount !== 8'd0) begin failures++;
      $display("FAIL reset_ovf got=%0b/%0d exp=0/0", overflow, dropCount); end
  endtask

  task automatic test_in_order();
    logic [7:0] exp_b [3] = '{8'h11, 8'h22, 8'h33};
    step(0, 1, 8'h11, 0, 0);
    checks++; if (outValid !== 1'b1 || outData !== 8'h11) begin failures++;
      $display("FAIL first_visible got=%0b/%h exp=1/11", outValid, outData); end
    step(0, 1, 8'h22, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    checks++; if (count !== 3'd3 || outData !== 8'h11) begin failures++;
      $display("FAIL order_fill got=%0d/%h exp=3/11", count, outData); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (outData !== exp_b[i]) begin failures++;
        $display("FAIL order_pop%0d got=%h exp=%h", i, outData, exp_b[i]); end
      step(0, 0, 8'h00, 1, 0);
    end
    checks++; if (count !== 3'd0 || outValid !== 1'b0) begin failures++;
      $display("FAIL order_empty got=%0d/%0b exp=0/0", count, outValid); end
    step(0, 0, 8'h00, 1, 0);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL underflow got=%0d exp=0", count); end
    step(0, 1, 8'h5C, 1, 0);
    checks++; if (count !== 3'd1 || outData !== 8'h5C) begin failures++;
      $display("FAIL empty_push_ready got=%0d/%h exp=1/5c", count, outData); end
    step(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(0, 1, 8'hA0 + 8'(i), 0, 0);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin failures++;
      $display("FAIL fill_full got=%0b/%0d exp=1/4", full, count); end
    step(0, 1, 8'hA4, 0, 0);
    checks++; if (overflow !== 1'b1 || dropCount !== 8'd1 || outData !== 8'hA0 || count !== 3'd4) begin failures++;
      $display("FAIL drop got=%0b/%0d/%h/%0d exp=1/1/a0/4", overflow, dropCount, outData, count); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB5};
    checks++; if (outData !== 8'hA0) begin failures++; $display("FAIL fpp_head got=%h exp=a0", outData); end
    step(0, 1, 8'hB5, 1, 0);
    checks++; if (count !== 3'd4 || full !== 1'b1) begin failures++;
      $display("FAIL fpp_count got=%0d/%0b exp=4/1", count, full); end
    step(0, 0, 8'h00, 0, 0);
    checks++; if (outData !== 8'hA1) begin failures++; $display("FAIL hold_stall got=%h exp=a1", outData); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (outData !== exp_b[i]) begin failures++;
        $display("FAIL fpp_drain%0d got=%h exp=%h", i, outData, exp_b[i]); end
      step(0, 0, 8'h00, 1, 0);
    end
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL fpp_empty got=%0b exp=0", outValid); end
  endtask

  task automatic test_drop_saturate();
    step(0, 0, 8'h00, 0, 1);
    checks++; if (overflow !== 1'b0 || dropCount !== 8'd0) begin failures++;
      $display("FAIL clear got=%0b/%0d exp=0/0", overflow, dropCount); end
    for (int i = 0; i < 4; i++) step(0, 1, 8'hC0 + 8'(i), 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 8'(i), 0, 0);
    checks++; if (dropCount !== 8'd255 || overflow !== 1'b1) begin failures++;
      $display("FAIL saturate got=%0d/%0b exp=255/1", dropCount, overflow); end
    checks++; if (outData !== 8'hC0 || count !== 3'd4) begin failures++;
      $display("FAIL drop_unchanged got=%h/%0d exp=c0/4", outData, count); end
    step(0, 1, 8'hEE, 0, 1);
    checks++; if (overflow !== 1'b1 || dropCount !== 8'd1) begin failures++;
      $display("FAIL clear_with_drop got=%0b/%0d exp=1/1", overflow, dropCount); end
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    int rx = 0;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b = 8'($urandom);
      sent.push_back(b);
      if (outValid) begin
        checks++; if (outData !== sent[rx]) begin failures++;
          $display("FAIL wrap_order%0d got=%h exp=%h", rx, outData, sent[rx]); end
        rx++;
      end
      step(0, 1, b, outValid, 0);
    end
    while (rx < sent.size()) begin
      checks++; if (outValid !== 1'b1 || outData !== sent[rx]) begin failures++;
        $display("FAIL wrap_tail%0d got=%0b/%h exp=1/%h", rx, outValid, outData, sent[rx]); end
      rx++;
      step(0, 0, 8'h00, 1, 0);
    end
  endtask

  task automatic test_reset_midstream();
    step(0, 1, 8'h01, 0, 0);
    step(0, 1, 8'h02, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h03, 0, 0);
    step(1, 1, 8'h04, 1, 1);
    checks++; if (count !== 3'd0 || outValid !== 1'b0 || overflow !== 1'b0 || dropCount !== 8'd0) begin failures++;
      $display("FAIL reset_mid got=%0d/%0b/%0b/%0d exp=0/0/0/0", count, outValid, overflow, dropCount); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit r   = ($urandom_range(0, 99) == 0);
      bit d   = ($urandom_range(0, 99) < 60);
      bit rdy = ($urandom_range(0, 99) < 40);
      bit clr = ($urandom_range(0, 15) == 0);
      step(r, d, 8'($urandom), rdy, clr);
      checks++;
      if (count !== 3'(mq.size()) || outValid !== (mq.size() != 0) || full !== (mq.size() == DEPTH) ||
          overflow !== movf || dropCount !== 8'(mdc) || (mq.size() != 0 && outData !== mq[0])) begin
        failures++;
        $display("FAIL rand%0d got cnt=%0d v=%0b f=%0b o=%0b dc=%0d d=%h exp cnt=%0d o=%0b dc=%0d d=%h",
                 i, count, outValid, full, overflow, dropCount, outData, mq.size(), movf, mdc,
                 (mq.size() != 0) ? mq[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_overflow();
    test_full_push_pop();
    test_drop_saturate();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
